// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith ops plus iterative unsigned
// multiply (shift-add) and divide (restoring), with valid/ready on both sides.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             illegal_op,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  typedef enum logic [2:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_ADD   = 3'b010,
    OP_MULTU = 3'b011,
    OP_DIVU  = 3'b100,
    OP_ILL   = 3'b101,
    OP_SUB   = 3'b110,
    OP_SLT   = 3'b111
  } op_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hacc_q, hacc_d;
  logic [WIDTH-1:0] lacc_q, lacc_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             ill_q, ill_d;

  op_t              op;
  logic             accept;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;
  logic [WIDTH:0]   rem_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_nx, div_quo_nx;

  assign op        = op_t'(alu_control);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_MUL) || (state_q == S_DIV);
  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;

  assign result     = result_q;
  assign hi         = hi_q;
  assign zero       = zero_q;
  assign illegal_op = ill_q;

  // Multiply: hacc holds the partial product high half, lacc shifts out the
  // multiplier while collecting the product low half.
  assign mul_sum   = {1'b0, hacc_q} + (lacc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_hi_nx = mul_sum[WIDTH:1];
  assign mul_lo_nx = {mul_sum[0], lacc_q[WIDTH-1:1]};

  // Divide: hacc is the partial remainder, lacc shifts the dividend out and
  // the quotient in. A zero divisor always "fits", giving all-ones / remainder a.
  assign rem_sh     = {hacc_q, lacc_q[WIDTH-1]};
  assign div_ge     = (rem_sh >= {1'b0, opb_q});
  assign div_rem_nx = div_ge ? (rem_sh[WIDTH-1:0] - opb_q) : rem_sh[WIDTH-1:0];
  assign div_quo_nx = {lacc_q[WIDTH-2:0], div_ge};

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = src_a + src_b;
      OP_SUB:  alu_res = src_a - src_b;
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hacc_d   = hacc_q;
    lacc_d   = lacc_q;
    opb_d    = opb_q;
    result_d = result_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    ill_d    = ill_q;

    case (state_q)
      S_MUL: begin
        hacc_d = mul_hi_nx;
        lacc_d = mul_lo_nx;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d  = S_DONE;
          result_d = mul_lo_nx;
          hi_d     = mul_hi_nx;
          zero_d   = (mul_lo_nx == '0);
          ill_d    = 1'b0;
        end
      end
      S_DIV: begin
        hacc_d = div_rem_nx;
        lacc_d = div_quo_nx;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d  = S_DONE;
          result_d = div_quo_nx;
          hi_d     = div_rem_nx;
          zero_d   = (div_quo_nx == '0);
          ill_d    = 1'b0;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: ;
    endcase

    // An accept in DONE overrides the return to IDLE, giving back-to-back beats.
    if (accept) begin
      cnt_d = '0;
      if (op == OP_MULTU || op == OP_DIVU) begin
        state_d = (op == OP_MULTU) ? S_MUL : S_DIV;
        hacc_d  = '0;
        lacc_d  = src_a;
        opb_d   = src_b;
      end else begin
        state_d  = S_DONE;
        result_d = alu_res;
        hi_d     = '0;
        zero_d   = (alu_res == '0);
        ill_d    = (op == OP_ILL);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hacc_q   <= '0;
      lacc_q   <= '0;
      opb_q    <= '0;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hacc_q   <= hacc_d;
      lacc_q   <= lacc_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      ill_q    <= ill_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner cases plus random ops
// compared against a plain-arithmetic reference model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_control;
  logic [31:0] src_a, src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result, hi;
  logic        zero, illegal_op, busy;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_control(alu_control),
    .src_a      (src_a),
    .src_b      (src_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .hi         (hi),
    .zero       (zero),
    .illegal_op (illegal_op),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {illegal, hi, lo} for one operation.
  function automatic logic [64:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] lo, h;
    logic        ill;
    p = '0; lo = '0; h = '0; ill = 1'b0;
    case (op)
      3'b010: lo = a + b;
      3'b110: lo = a - b;
      3'b000: lo = a & b;
      3'b001: lo = a | b;
      3'b111: lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b011: begin p = 64'(a) * 64'(b); h = p[63:32]; lo = p[31:0]; end
      3'b100: begin
        if (b == 32'd0) begin lo = 32'hFFFF_FFFF; h = a; end
        else begin lo = a / b; h = a % b; end
      end
      default: ill = 1'b1;
    endcase
    return {ill, h, lo};
  endfunction

  // Called at a negedge with the unit idle; returns at a negedge, unit idle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [64:0] exp;
    int exp_lat;
    int lat;
    exp     = model(op, a, b);
    exp_lat = (op == 3'b011 || op == 3'b100) ? 33 : 1;
    in_valid = 1'b1; alu_control = op; src_a = a; src_b = b; out_ready = 1'b0;
    #1 check({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0; alu_control = 3'($urandom); src_a = $urandom; src_b = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      check({tag, ".busy"}, 64'(busy), 64'd1);
      check({tag, ".in_ready_busy"}, 64'(in_ready), 64'd0);
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".result"}, 64'(result), 64'(exp[31:0]));
    check({tag, ".hi"}, 64'(hi), 64'(exp[63:32]));
    check({tag, ".zero"}, 64'(zero), 64'(exp[31:0] == 32'd0));
    check({tag, ".illegal"}, 64'(illegal_op), 64'(exp[64]));
    check({tag, ".busy_done"}, 64'(busy), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".drained"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int stray;

    rst = 1'b1; in_valid = 1'b0; alu_control = '0; src_a = '0; src_b = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.result", 64'(result), 64'd0);
    check("reset.hi", 64'(hi), 64'd0);
    check("reset.zero", 64'(zero), 64'd0);
    check("reset.illegal", 64'(illegal_op), 64'd0);
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    run_op(3'b010, 32'h7FFF_FFFF, 32'd1, "add_wrap");
    run_op(3'b110, 32'd5, 32'd5, "sub_zero");
    run_op(3'b111, 32'hFFFF_FFFF, 32'd1, "slt_neg");
    run_op(3'b111, 32'd1, 32'hFFFF_FFFF, "slt_pos");
    run_op(3'b000, 32'h0000_F0F0, 32'h0000_0FF0, "and");
    run_op(3'b001, 32'h0000_F0F0, 32'h0000_0FF0, "or");
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run_op(3'b100, 32'd100, 32'd7, "divu");
    run_op(3'b100, 32'h0000_1234, 32'd0, "divu_by0");
    run_op(3'b101, 32'h1234_5678, 32'h9ABC_DEF0, "illegal");

    // Backpressure, then a back-to-back accept while the held beat drains.
    in_valid = 1'b1; alu_control = 3'b010; src_a = 32'd10; src_b = 32'd20; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      src_a = $urandom; src_b = $urandom;
      #1;
      check("bp.out_valid", 64'(out_valid), 64'd1);
      check("bp.result", 64'(result), 64'd30);
      check("bp.hi", 64'(hi), 64'd0);
      check("bp.in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1; in_valid = 1'b1; alu_control = 3'b010;
    src_a = 32'h0000_0100; src_b = 32'h0000_0023;
    #1 check("b2b.in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b.out_valid", 64'(out_valid), 64'd1);
    check("b2b.result", 64'(result), 64'h123);
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b.drained", 64'(out_valid), 64'd0);

    // Reset during the tenth MULTU iteration must drop the op silently.
    in_valid = 1'b1; alu_control = 3'b011; src_a = 32'hDEAD_BEEF; src_b = 32'h1234_5678;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("abort.busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort.out_valid", 64'(out_valid), 64'd0);
    check("abort.busy", 64'(busy), 64'd0);
    check("abort.in_ready", 64'(in_ready), 64'd1);
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    check("abort.stray_beats", 64'(stray), 64'd0);

    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 5) == 0) rb = 32'd0;
      else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 300));
      run_op(rop, ra, rb, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
